// File: rtl/alu_seq.sv
// Sequencer around an external combinational ALU: latches an op, drives the ALU
// from a 4x8 register file, and writes back the result and ADD/SUB flags.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [1:0] op_rd,
  input  logic [1:0] op_ra,
  input  logic [1:0] op_rb,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       alu_m,
  output logic [3:0] alu_s,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_t,
  input  logic       alu_cf,
  input  logic       alu_zf,
  output logic [7:0] result,
  output logic       cf,
  output logic       zf,
  output logic       done,
  output logic       err,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef struct packed {
    logic [2:0] code;
    logic [1:0] rd;
  } op_t;

  state_e          state_q, state_d;
  logic            exec_cnt_q, exec_cnt_d;
  op_t             op_q;
  logic [3:0][7:0] rf_q;
  logic            m_q, dec_m;
  logic [3:0]      s_q, dec_s;
  logic [7:0]      a_q, b_q, res_q;
  logic            cf_q, zf_q;
  logic            accept, wb, legal, arith;

  assign op_ready = (state_q == IDLE) && !rst;
  assign accept   = op_valid && op_ready;
  assign legal    = !(op_q.code[2] && op_q.code[1]);
  assign arith    = (op_q.code == 3'b010) || (op_q.code == 3'b011);
  // EXEC spans two cycles; writeback happens when leaving its second cycle
  assign wb       = (state_q == EXEC) && exec_cnt_q;

  always_comb begin
    state_d    = state_q;
    exec_cnt_d = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: if (exec_cnt_q) state_d = DONE;
            else exec_cnt_d = 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    {dec_m, dec_s} = 5'b0_0000;
    case (op_code)
      3'b000: {dec_m, dec_s} = 5'b0_1100;
      3'b001: {dec_m, dec_s} = 5'b0_1010;
      3'b010: {dec_m, dec_s} = 5'b1_1001;
      3'b011: {dec_m, dec_s} = 5'b1_0110;
      3'b100: {dec_m, dec_s} = 5'b1_1011;
      3'b101: {dec_m, dec_s} = 5'b1_0101;
      default: {dec_m, dec_s} = 5'b0_0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      exec_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  // ALU drive: operands sampled from pre-edge rf, no load forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      m_q  <= 1'b0;
      s_q  <= 4'b0000;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= '{code: op_code, rd: op_rd};
      m_q  <= dec_m;
      s_q  <= dec_s;
      a_q  <= rf_q[op_ra];
      b_q  <= rf_q[op_rb];
    end else if (state_q == DONE) begin
      m_q  <= 1'b0;
      s_q  <= 4'b0000;
      a_q  <= '0;
      b_q  <= '0;
    end
  end

  // Writeback is ordered after the load so it wins a same-register collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q  <= '0;
      res_q <= '0;
      cf_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      if (ld_en) rf_q[ld_addr] <= ld_data;
      if (wb && legal) begin
        rf_q[op_q.rd] <= alu_t;
        res_q         <= alu_t;
        if (arith) begin
          cf_q <= alu_cf;
          zf_q <= alu_zf;
        end
      end
    end
  end

  assign alu_m    = m_q;
  assign alu_s    = s_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign result   = res_q;
  assign cf       = cf_q;
  assign zf       = zf_q;
  assign done     = (state_q == DONE) && legal;
  assign err      = (state_q == DONE) && !legal;
  assign dbg_data = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: external ALU model plus an op-level reference model of the
// register file, result and flags; directed scenarios followed by random ops.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid, op_ready;
  logic [2:0] op_code;
  logic [1:0] op_rd, op_ra, op_rb;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic       alu_m;
  logic [3:0] alu_s;
  logic [7:0] alu_a, alu_b, alu_t;
  logic       alu_cf, alu_zf;
  logic [7:0] result;
  logic       cf, zf, done, err;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_rf [4];
  logic [7:0] m_res;
  logic       m_cf, m_zf;

  alu_seq dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_rd(op_rd), .op_ra(op_ra), .op_rb(op_rb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_m(alu_m), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_t(alu_t), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .result(result), .cf(cf), .zf(zf), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External combinational ALU, selected by mode/function code
  always_comb begin
    alu_t  = 8'h00;
    alu_cf = 1'b0;
    case ({alu_m, alu_s})
      5'b0_1100: alu_t = alu_a;
      5'b0_1010: alu_t = alu_b;
      5'b1_1001: {alu_cf, alu_t} = {1'b0, alu_a} + {1'b0, alu_b};
      5'b1_0110: {alu_cf, alu_t} = {1'b0, alu_b} - {1'b0, alu_a};
      5'b1_1011: alu_t = alu_a & alu_b;
      5'b1_0101: alu_t = ~alu_b;
      default:   alu_t = 8'h00;
    endcase
    alu_zf = (alu_t == 8'h00);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_ms(input logic [2:0] code);
    case (code)
      3'd0: return 5'b0_1100;
      3'd1: return 5'b0_1010;
      3'd2: return 5'b1_1001;
      3'd3: return 5'b1_0110;
      3'd4: return 5'b1_1011;
      3'd5: return 5'b1_0101;
      default: return 5'b0_0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_res = 8'h00; m_cf = 1'b0; m_zf = 1'b0;
  endtask

  task automatic ld(input logic [1:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_rf[addr] = data;
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      chk(tag, dbg_data, m_rf[i]);
    end
  endtask

  // Runs one op starting from IDLE (#1 after an edge); optional load on the writeback edge
  task automatic do_op(input logic [2:0] code, input logic [1:0] rd, ra, rb,
                       input bit cl_en, input logic [1:0] cl_addr, input logic [7:0] cl_data);
    int a, b, r, sum;
    bit legal, fl, c;
    a = int'(m_rf[ra]); b = int'(m_rf[rb]);
    legal = (code < 3'd6); fl = 1'b0; c = 1'b0; r = 0;
    case (code)
      3'd0: r = a;
      3'd1: r = b;
      3'd2: begin sum = a + b; r = sum % 256; c = (sum > 255); fl = 1'b1; end
      3'd3: begin r = (b - a + 256) % 256; c = (b < a); fl = 1'b1; end
      3'd4: r = a & b;
      3'd5: r = 255 - b;
      default: r = 0;
    endcase
    chk("ready_idle", {7'd0, op_ready}, 8'd1);
    op_valid = 1'b1; op_code = code; op_rd = rd; op_ra = ra; op_rb = rb;
    @(posedge clk); #1;
    op_valid = 1'($urandom_range(0, 1));
    op_code = 3'($urandom); op_rd = 2'($urandom); op_ra = 2'($urandom); op_rb = 2'($urandom);
    chk("exec_ms", {3'd0, alu_m, alu_s}, {3'd0, exp_ms(code)});
    chk("exec_a", alu_a, 8'(a));
    chk("exec_b", alu_b, 8'(b));
    chk("exec_ready", {7'd0, op_ready}, 8'd0);
    chk("exec_done", {6'd0, done, err}, 8'd0);
    if (cl_en) begin ld_en = 1'b1; ld_addr = cl_addr; ld_data = cl_data; end
    @(posedge clk); #1;
    chk("exec2_done", {6'd0, done, err}, 8'd0);
    @(posedge clk); #1;
    ld_en = 1'b0; op_valid = 1'b0;
    if (cl_en) m_rf[cl_addr] = cl_data;
    if (legal) begin
      m_rf[rd] = 8'(r); m_res = 8'(r);
      if (fl) begin m_cf = c; m_zf = (r == 0); end
    end
    chk("done", {7'd0, done}, {7'd0, legal});
    chk("err", {7'd0, err}, {7'd0, !legal});
    chk("result", result, m_res);
    chk("flags", {6'd0, cf, zf}, {6'd0, m_cf, m_zf});
    dbg_addr = rd; #1;
    chk("rf_rd", dbg_data, m_rf[rd]);
    @(posedge clk); #1;
    chk("idle_ready", {7'd0, op_ready}, 8'd1);
    chk("idle_alu", {3'd0, alu_m, alu_s}, 8'd0);
    chk("idle_ab", alu_a | alu_b, 8'd0);
    chk("idle_pulse", {6'd0, done, err}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_rd = '0; op_ra = '0; op_rb = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", {7'd0, op_ready}, 8'd0);
    chk("rst_alu", {3'd0, alu_m, alu_s}, 8'd0);
    chk("rst_ab", alu_a | alu_b, 8'd0);
    chk("rst_out", {3'd0, cf, zf, done, err, 1'b0}, 8'd0);
    chk("rst_result", result, 8'd0);
    rst = 1'b0; #1;
    chk("post_rst_ready", {7'd0, op_ready}, 8'd1);
    chk_rf("rst_rf");

    // SUB borrow
    ld(2'd1, 8'h05); ld(2'd2, 8'h03);
    do_op(3'b011, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
    chk("sub_res", result, 8'hFE);
    chk("sub_flags", {6'd0, cf, zf}, 8'b10);
    // ADD overflow
    ld(2'd1, 8'h80); ld(2'd2, 8'h80);
    do_op(3'b010, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
    chk("add_res", result, 8'h00);
    chk("add_flags", {6'd0, cf, zf}, 8'b11);
    // Logic ops leave flags alone
    ld(2'd1, 8'hF0); ld(2'd2, 8'h3C);
    do_op(3'b100, 2'd2, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
    chk("and_res", result, 8'h30);
    chk("and_flags", {6'd0, cf, zf}, 8'b11);
    do_op(3'b101, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
    chk("not_res", result, 8'hCF);
    // Illegal opcodes
    do_op(3'b110, 2'd1, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00);
    do_op(3'b111, 2'd2, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00);
    chk("illegal_res", result, 8'hCF);
    chk_rf("illegal_rf");
    // Load collision on writeback, then a load to a different register
    ld(2'd1, 8'h55);
    do_op(3'b000, 2'd3, 2'd1, 2'd0, 1'b1, 2'd3, 8'hAA);
    dbg_addr = 2'd3; #1;
    chk("collide", dbg_data, 8'h55);
    do_op(3'b001, 2'd2, 2'd0, 2'd1, 1'b1, 2'd0, 8'h77);
    chk_rf("noncollide_rf");

    // Reset during EXEC
    ld(2'd1, 8'h11);
    op_valid = 1'b1; op_code = 3'b010; op_rd = 2'd1; op_ra = 2'd1; op_rb = 2'd1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    rst = 1'b1; ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h99; #1;
    model_reset();
    chk("mid_rst_ready", {7'd0, op_ready}, 8'd0);
    chk("mid_rst_alu", {3'd0, alu_m, alu_s}, 8'd0);
    chk("mid_rst_ab", alu_a | alu_b, 8'd0);
    chk("mid_rst_out", {4'd0, cf, zf, done, err}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0; ld_en = 1'b0;
    chk_rf("mid_rst_rf");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_nodone", {6'd0, done, err}, 8'd0);
    end
    ld(2'd0, 8'h21);
    do_op(3'b010, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    chk("post_rst_add", result, 8'h42);

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) ld(2'($urandom), 8'($urandom));
      do_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom));
    end
    chk_rf("final_rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port op_valid, input, 1, operation request.
REQ-004 SHALL have port op_ready, output, 1, block can accept an operation.
REQ-005 SHALL have port op_code, input, 3, operation code.
- 000 PASSA, 001 PASSB, 010 ADD, 011 SUB (b-a), 100 AND, 101 NOT (~b).
- 110 and 111 are illegal.
REQ-006 SHALL have ports op_rd, op_ra, op_rb, input, 2 each, destination, operand-a and operand-b register indices.
REQ-007 SHALL have ports ld_en (1), ld_addr (2), ld_data (8), input, register-file load port.
REQ-008 SHALL have ports alu_m (1), alu_s (4), alu_a (8), alu_b (8), output, registered drive to the external combinational ALU.
REQ-009 SHALL have ports alu_t (8), alu_cf (1), alu_zf (1), input, ALU result and flags.
REQ-010 SHALL have ports result (8), cf (1), zf (1), output, last written result and flag register.
REQ-011 SHALL have ports done (1) and err (1), output, single-cycle completion and illegal-op pulses.
REQ-012 SHALL have ports dbg_addr (2) input and dbg_data (8) output; dbg_data is a combinational read of rf[dbg_addr].

Function
REQ-013 SHALL hold a 4x8 register file rf[0..3].
REQ-014 SHALL implement states IDLE, EXEC and DONE.
- op_ready is 1 only in IDLE with rst low.
REQ-015 SHALL accept an operation on the edge where op_valid and op_ready are both 1, then go IDLE->EXEC.
- On that edge, op_code and op_rd are latched.
- alu_a is loaded with rf[op_ra] and alu_b with rf[op_rb], using pre-edge rf contents (no ld forwarding).
REQ-016 SHALL load alu_m/alu_s on the accept edge as follows.
- PASSA 0/1100, PASSB 0/1010, ADD 1/1001, SUB 1/0110, AND 1/1011, NOT 1/0101.
- Illegal opcodes 0/0000.
- In IDLE, alu_m/alu_s read 0/0000.
REQ-017 SHALL act on the EXEC->DONE edge as follows.
- Legal op: write alu_t into rf[rd] and into result; set done=1 for the DONE cycle.
- Illegal op: no rf write, result unchanged, done stays 0, err=1 for the DONE cycle.
REQ-018 SHALL update cf/zf from alu_cf/alu_zf only for ADD and SUB; all other ops leave cf/zf unchanged.
REQ-019 SHALL return DONE->IDLE unconditionally.
- Latency: accept at edge N; done/err high in the cycle after edge N+2; op_ready is high again after edge N+3.
- Maximum throughput is one op per 3 cycles.
REQ-020 SHALL accept ld_en writes in any state.
- If a ld_en write and a writeback hit the same register on the same edge, the writeback wins.
- A ld_en write to a different register proceeds normally.
REQ-021 SHALL ignore op_valid outside IDLE.
- Request fields may change freely while op_ready=0.
REQ-022 SHALL clear alu_a/alu_b to 0 on return to IDLE.

Reset
REQ-023 SHALL, while rst=1, asynchronously force the following.
- State IDLE, rf[0..3]=0.
- alu_m=0, alu_s=0000, alu_a=alu_b=0.
- result=0, cf=0, zf=0, done=0, err=0, op_ready=0.
REQ-024 SHALL, when rst is asserted in EXEC or DONE, abandon the operation with no rf write and no done/err pulse; ld_en is ignored while rst=1.

Verification
REQ-025 SHALL cover ADD overflow: load r1=0x80, r2=0x80; ADD rd=3 ra=1 rb=2.
- alu_m=1, alu_s=1001 in EXEC.
- done 2 cycles after accept; result=0x00, cf=1, zf=1, rf[3]=0x00.
REQ-026 SHALL cover SUB borrow: r1=0x05, r2=0x03; SUB rd=0 ra=1 rb=2.
- result=0xFE, cf=1, zf=0, rf[0]=0xFE.
REQ-027 SHALL cover flag hold: after REQ-025, r1=0xF0, r2=0x3C; AND rd=2.
- result=0x30, cf=1, zf=1 unchanged.
- Then NOT rb=2 gives result=0xCF.
REQ-028 SHALL cover illegal op: op_code=110.
- err pulse one cycle, done=0, rf, result and flags unchanged, op_ready back in IDLE.
REQ-029 SHALL cover reset mid-op: rst pulsed during EXEC of ADD rd=1.
- rf[1]=0, no done, all outputs at reset values, then a new op is accepted normally.
REQ-030 SHALL cover load collision: ld_en ld_addr=3 ld_data=0xAA on the same edge as writeback of 0x55 to rf[3].
- dbg_data at dbg_addr=3 reads 0x55.
